crc32_stream_gen: RTL and testbench
===================================

Name: crc32_stream_gen

Overview:
Parametrised streaming CRC-32 generator/appender for byte-oriented packet paths, with a valid/ready handshake on both sides.
- Accepts frames DATA_W bits wide per beat with per-byte keep.
- Computes the CRC across all valid bytes and forwards the payload with one register stage of latency.
- After the last payload beat, appends the 4-byte FCS as extra beats.
- Sits between the packet builder and the MAC/serialiser; replaces the fixed 8-bit CRC register.

Parameters:
DATA_W, 8, beat width in bits; legal values 8, 16, 32, 64.
POLY, 32'h04C11DB7, generator polynomial in normal (MSB-first) form.
INIT, 32'hFFFFFFFF, CRC register value at frame start.
XOROUT, 32'hFFFFFFFF, value XORed into the register to form the FCS.
RESIDUE, 32'hDEBB20E3, good-frame register residue; used only with CRC32_CHECK_EN.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous abort of the current frame
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid & s_ready
s_data  in  DATA_W  input bytes; byte 0 = s_data[7:0] is first on the wire
s_keep  in  DATA_W/8  byte enables, contiguous from bit 0
s_last  in  1  last payload beat of frame
m_valid  out  1  output beat valid
m_ready  in  1  downstream accept
m_data  out  DATA_W  output bytes
m_keep  out  DATA_W/8  output byte enables
m_last  out  1  last beat of frame, including FCS
crc_out  out  32  FCS of the last completed frame (register ^ XOROUT)
crc_done  out  1  one-cycle pulse when crc_out updates

Behaviour:
- Reflected (Ethernet) LFSR:
  - Data bit 0 of each byte enters first; register shifts right using the bit-reversed POLY.
  - Per beat, bytes with keep=1 are folded in ascending byte order; bytes with keep=0 leave the register unchanged.
- Reset values: m_valid=0, m_data=0, m_keep=0, m_last=0, crc_out=0, crc_done=0, crc register=INIT, state=IDLE.
- States:
  - IDLE: waiting for the first beat of a frame.
  - DATA: frame in progress.
  - APPEND: emitting FCS beats.
- IDLE->DATA on the first accepted beat with s_last=0.
- IDLE or DATA -> APPEND on an accepted beat with s_last=1.
- APPEND -> IDLE after the final FCS beat is accepted downstream.
- Handshake:
  - s_ready = (~m_valid | m_ready) & (state != APPEND) & ~flush.
  - Output register loads on any accepted beat.
  - m_valid holds with stable m_data/m_keep/m_last until m_ready.
- Latency: payload beat appears on m_* the cycle after acceptance.
- Payload beats are forwarded with m_last=0. m_last is asserted only on the final FCS beat.
- FCS = register ^ XOROUT, emitted LSB byte first.
- FCS beat count = ceil(32/DATA_W):
  - DATA_W=8: 4 beats, keep=1.
  - DATA_W=16: 2 beats.
  - DATA_W=32: 1 beat, keep=4'hF.
  - DATA_W=64: 1 beat, keep=8'h0F, upper bytes 0.
- crc_out and crc_done update in the cycle the first FCS beat is loaded into the output register. The CRC register then reloads INIT.
- s_last with s_keep=0 is legal: nothing is folded and the FCS is still appended. s_keep=0 on a non-last beat is illegal; the beat is ignored for the CRC but still forwarded.
- Back-pressure in APPEND freezes the FCS byte index; there is no skipping or duplication.
- flush, at any state:
  - Next state IDLE, CRC register=INIT, m_valid=0, FCS index=0.
  - crc_out is unchanged and there is no crc_done pulse.
  - flush overrides a simultaneous s_valid.
- reset mid-frame or mid-APPEND returns all state to reset values immediately.
- A back-to-back frame may be accepted in the cycle after the last FCS beat handshake.

Optional Feature:
CRC32_CHECK_EN:
- When defined, adds input check_mode (1) and outputs crc_ok (1) and crc_ok_vld (1).
- With check_mode=1, the received frame already contains its FCS:
  - Bytes are folded including the FCS.
  - No append; APPEND is skipped and m_last is passed through from s_last.
  - On the last accepted beat, crc_ok = (register == RESIDUE), with a one-cycle crc_ok_vld pulse aligned with the m_last beat.
- check_mode is sampled on the first beat of a frame and is ignored mid-frame.
- Without the macro, these ports are absent and behaviour is generator-only.

Test Plan:
1. DATA_W=8, "123456789" (0x31..0x39), m_ready=1 -> 9 payload beats, then FCS beats 0x26, 0x39, 0xF4, 0xCB; m_last on 0xCB; crc_out=32'hCBF43926.
2. DATA_W=32, beats 32'h34333231, 32'h38373635, 32'h00000039 (keep=4'h1, last) -> one FCS beat 32'hCBF43926, keep=4'hF, m_last=1; crc_done pulses once.
3. DATA_W=8, same frame with m_ready toggling 1/0 every cycle -> byte stream identical to test 1; no beat lost or duplicated; s_ready=0 throughout APPEND.
4. Assert flush after 5 bytes, then send "123456789" -> only the second frame is output; crc_out=32'hCBF43926; no crc_done for the aborted frame.
5. Assert reset during the second FCS beat -> all outputs 0 next cycle; a following frame yields the correct CRC from INIT.
6. With CRC32_CHECK_EN, check_mode=1, "123456789" followed by 0x26, 0x39, 0xF4, 0xCB -> crc_ok=1 with crc_ok_vld. Flip one payload bit -> crc_ok=0.

Source files
------------

// File: rtl/crc32_stream_gen.sv
// crc32_stream_gen
// Streaming CRC-32 generator/appender for byte-oriented packet paths.
// Payload beats pass through a single output register (one cycle latency),
// the CRC is folded over every kept byte, and after the last payload beat
// the FCS (register ^ XOROUT, LSB byte first) is emitted as extra beats.
//
// Optional feature macro: CRC32_CHECK_EN
//   Adds check_mode / crc_ok / crc_ok_vld and the RESIDUE parameter. In check
//   mode the frame already carries its FCS, nothing is appended, and the
//   register is compared against RESIDUE on the last beat.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   flush             synchronous abort of the current frame
//   s_valid/s_ready   input handshake; s_data/s_keep/s_last input beat
//   m_valid/m_ready   output handshake; m_data/m_keep/m_last output beat
//   crc_out           FCS of the last completed frame
//   crc_done          one-cycle pulse when crc_out updates
//   dbg_state         current FSM state (0 idle, 1 data, 2 append)
//   check_mode, crc_ok, crc_ok_vld   only with CRC32_CHECK_EN
//
// Handshake: a beat transfers on a rising edge where valid & ready are both
// high. A source holding valid keeps its beat stable until it transfers;
// ready may change freely. s_ready is combinational from the output register
// state, the FSM state and flush.
module crc32_stream_gen #(
  parameter int          DATA_W = 8,
  parameter logic [31:0] POLY   = 32'h04C11DB7,
  parameter logic [31:0] INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT = 32'hFFFFFFFF
`ifdef CRC32_CHECK_EN
  ,
  parameter logic [31:0] RESIDUE = 32'hDEBB20E3
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  input  logic [DATA_W/8-1:0]   s_keep,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_W-1:0]     m_data,
  output logic [DATA_W/8-1:0]   m_keep,
  output logic                  m_last,
  output logic [31:0]           crc_out,
  output logic                  crc_done,
`ifdef CRC32_CHECK_EN
  input  logic                  check_mode,
  output logic                  crc_ok,
  output logic                  crc_ok_vld,
`endif
  output logic [1:0]            dbg_state
);

  localparam int NB        = DATA_W / 8;
  localparam int FCS_BEATS = (32 + DATA_W - 1) / DATA_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_APPEND = 2'd2
  } state_t;

  function automatic logic [31:0] rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  // The register shifts right, so the polynomial is used bit-reversed.
  localparam logic [31:0] POLY_R = rev32(POLY);

  function automatic logic [31:0] fold_byte(input logic [31:0] crc,
                                            input logic [7:0]  b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ POLY_R) : (c >> 1);
    return c;
  endfunction

  function automatic logic [31:0] fold_beat(input logic [31:0]       crc,
                                            input logic [DATA_W-1:0] data,
                                            input logic [NB-1:0]     keep);
    logic [31:0] c;
    c = crc;
    for (int b = 0; b < NB; b++)
      if (keep[b]) c = fold_byte(c, data[8*b +: 8]);
    return c;
  endfunction

  state_t              r_state;
  logic [31:0]         r_crc;
  logic [2:0]          r_fcs_idx;
  logic                r_m_valid;
  logic [DATA_W-1:0]   r_m_data;
  logic [NB-1:0]       r_m_keep;
  logic                r_m_last;
  logic [31:0]         r_crc_out;
  logic                r_crc_done;
`ifdef CRC32_CHECK_EN
  logic                r_check;
  logic                r_crc_ok;
  logic                r_crc_ok_vld;
  logic                w_check;
`endif

  logic                w_out_free;
  logic                w_s_ready;
  logic                w_accept;
  logic [31:0]         w_crc_next;
  logic [31:0]         w_fcs_val;
  logic [63:0]         w_fcs_shift;
  logic [DATA_W-1:0]   w_fcs_beat;
  logic [NB-1:0]       w_fcs_keep;
  logic                w_fcs_pending;
  logic                w_fcs_is_last;

  assign w_out_free = ~r_m_valid | m_ready;
  assign w_s_ready  = w_out_free & (r_state != S_APPEND) & ~flush;
  assign w_accept   = s_valid & w_s_ready;
  assign w_crc_next = fold_beat(r_crc, s_data, s_keep);

  // The register is reloaded with INIT once the first FCS beat is taken, so
  // later FCS beats read the captured value back from crc_out.
  assign w_fcs_val     = (r_fcs_idx == 3'd0) ? (r_crc ^ XOROUT) : r_crc_out;
  assign w_fcs_shift   = {32'h0, w_fcs_val} >> (DATA_W * int'(r_fcs_idx));
  assign w_fcs_beat    = w_fcs_shift[DATA_W-1:0];
  assign w_fcs_pending = (r_fcs_idx < 3'(FCS_BEATS));
  assign w_fcs_is_last = (r_fcs_idx == 3'(FCS_BEATS - 1));

  // Only the bytes that still hold FCS are enabled (wide beats carry the
  // FCS in their low 4 bytes).
  always_comb begin
    w_fcs_keep = '0;
    for (int b = 0; b < NB; b++)
      w_fcs_keep[b] = ((int'(r_fcs_idx) * NB + b) < 4);
  end

`ifdef CRC32_CHECK_EN
  // check_mode is only looked at on the first beat of a frame.
  assign w_check = (r_state == S_IDLE) ? check_mode : r_check;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_crc        <= INIT;
      r_fcs_idx    <= '0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_m_keep     <= '0;
      r_m_last     <= 1'b0;
      r_crc_out    <= '0;
      r_crc_done   <= 1'b0;
`ifdef CRC32_CHECK_EN
      r_check      <= 1'b0;
      r_crc_ok     <= 1'b0;
      r_crc_ok_vld <= 1'b0;
`endif
    end else begin
      r_crc_done   <= 1'b0;
`ifdef CRC32_CHECK_EN
      r_crc_ok_vld <= 1'b0;
`endif
      if (flush) begin
        r_state   <= S_IDLE;
        r_crc     <= INIT;
        r_m_valid <= 1'b0;
        r_fcs_idx <= '0;
      end else begin
        case (r_state)
          S_IDLE, S_DATA: begin
            if (w_accept) begin
              r_m_valid <= 1'b1;
              r_m_data  <= s_data;
              r_m_keep  <= s_keep;
`ifdef CRC32_CHECK_EN
              r_check   <= w_check;
              r_m_last  <= w_check & s_last;
              if (w_check && s_last) begin
                r_crc_ok     <= (w_crc_next == RESIDUE);
                r_crc_ok_vld <= 1'b1;
                r_crc        <= INIT;
                r_state      <= S_IDLE;
              end else begin
                r_crc   <= w_crc_next;
                r_state <= s_last ? S_APPEND : S_DATA;
              end
`else
              r_m_last  <= 1'b0;
              r_crc     <= w_crc_next;
              r_state   <= s_last ? S_APPEND : S_DATA;
`endif
            end else if (m_ready) begin
              r_m_valid <= 1'b0;
            end
          end
          S_APPEND: begin
            if (w_out_free) begin
              if (w_fcs_pending) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_fcs_beat;
                r_m_keep  <= w_fcs_keep;
                r_m_last  <= w_fcs_is_last;
                r_fcs_idx <= r_fcs_idx + 3'd1;
                if (r_fcs_idx == 3'd0) begin
                  r_crc_out  <= w_fcs_val;
                  r_crc_done <= 1'b1;
                  r_crc      <= INIT;
                end
              end else begin
                // Final FCS beat has just been taken downstream.
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
                r_fcs_idx <= '0;
                r_state   <= S_IDLE;
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign s_ready    = w_s_ready;
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_keep     = r_m_keep;
  assign m_last     = r_m_last;
  assign crc_out    = r_crc_out;
  assign crc_done   = r_crc_done;
  assign dbg_state  = r_state;
`ifdef CRC32_CHECK_EN
  assign crc_ok     = r_crc_ok;
  assign crc_ok_vld = r_crc_ok_vld;
`endif

endmodule

// File: tb/tb_crc32_stream_gen.sv
// Testbench for crc32_stream_gen: an 8-bit and a 32-bit instance share the
// clock, reset and flush. Expected beats and CRCs are hand-computed.
module tb_crc32_stream_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic flush = 1'b0;

  // ---------------- 8-bit instance ----------------
  logic        s8_valid = 1'b0;
  logic        s8_ready;
  logic [7:0]  s8_data = '0;
  logic [0:0]  s8_keep = '0;
  logic        s8_last = 1'b0;
  logic        m8_valid;
  logic        m8_ready = 1'b1;
  logic [7:0]  m8_data;
  logic [0:0]  m8_keep;
  logic        m8_last;
  logic [31:0] crc8_out;
  logic        crc8_done;
  logic [1:0]  dbg8;

  // ---------------- 32-bit instance ----------------
  logic        s32_valid = 1'b0;
  logic        s32_ready;
  logic [31:0] s32_data = '0;
  logic [3:0]  s32_keep = '0;
  logic        s32_last = 1'b0;
  logic        m32_valid;
  logic        m32_ready = 1'b1;
  logic [31:0] m32_data;
  logic [3:0]  m32_keep;
  logic        m32_last;
  logic [31:0] crc32_out;
  logic        crc32_done;
  logic [1:0]  dbg32;

`ifdef CRC32_CHECK_EN
  logic check_mode8 = 1'b0;
  logic crc_ok8, crc_ok_vld8;
  logic check_mode32 = 1'b0;
  logic crc_ok32, crc_ok_vld32;
`endif

  crc32_stream_gen #(.DATA_W(8)) dut8 (
    .clk(clk), .reset(reset), .flush(flush),
    .s_valid(s8_valid), .s_ready(s8_ready), .s_data(s8_data),
    .s_keep(s8_keep), .s_last(s8_last),
    .m_valid(m8_valid), .m_ready(m8_ready), .m_data(m8_data),
    .m_keep(m8_keep), .m_last(m8_last),
    .crc_out(crc8_out), .crc_done(crc8_done),
`ifdef CRC32_CHECK_EN
    .check_mode(check_mode8), .crc_ok(crc_ok8), .crc_ok_vld(crc_ok_vld8),
`endif
    .dbg_state(dbg8)
  );

  crc32_stream_gen #(.DATA_W(32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush),
    .s_valid(s32_valid), .s_ready(s32_ready), .s_data(s32_data),
    .s_keep(s32_keep), .s_last(s32_last),
    .m_valid(m32_valid), .m_ready(m32_ready), .m_data(m32_data),
    .m_keep(m32_keep), .m_last(m32_last),
    .crc_out(crc32_out), .crc_done(crc32_done),
`ifdef CRC32_CHECK_EN
    .check_mode(check_mode32), .crc_ok(crc_ok32), .crc_ok_vld(crc_ok_vld32),
`endif
    .dbg_state(dbg32)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  logic [9:0]  exp8_q[$];       // {last, keep, data}
  logic [31:0] exp_crc8_q[$];
  logic [36:0] exp32_q[$];      // {last, keep, data}
  logic [31:0] exp_crc32_q[$];
  int          done8_cnt  = 0;
  int          done32_cnt = 0;

  logic toggle_rdy   = 1'b0;
  logic skip_app_chk = 1'b0;
  logic in_append    = 1'b0;
  logic prev_last    = 1'b0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // m8_ready: held high, or toggled every cycle for back-pressure tests.
  always @(posedge clk) begin
    #1;
    m8_ready = toggle_rdy ? ~m8_ready : 1'b1;
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin
    logic [9:0] e;
    if (reset) begin
      in_append = 1'b0;
      prev_last = 1'b0;
    end else begin
      if (crc8_done) done8_cnt++;
      if (in_append && !skip_app_chk) check("s_ready_in_append", s8_ready, 0);
      if (prev_last && s8_valid && !flush) check("b2b_accept", s8_ready, 1);
      prev_last = 1'b0;
      if (m8_valid && m8_ready) begin
        if (exp8_q.size() == 0) begin
          total++; bad++;
          $display("FAIL beat8_extra: got %0h expected none",
                   {m8_last, m8_keep, m8_data});
        end else begin
          e = exp8_q.pop_front();
          check("beat8", {m8_last, m8_keep, m8_data}, e);
        end
        if (m8_last) begin
          in_append = 1'b0;
          prev_last = 1'b1;
          if (exp_crc8_q.size() != 0)
            check("crc8_out", crc8_out, exp_crc8_q.pop_front());
        end
      end
      if (flush) in_append = 1'b0;
      if (s8_valid && s8_ready && s8_last) in_append = 1'b1;
    end
  end

  // Monitor for the 32-bit instance.
  always @(negedge clk) begin
    logic [36:0] e;
    if (!reset) begin
      if (crc32_done) done32_cnt++;
      if (m32_valid && m32_ready) begin
        if (exp32_q.size() == 0) begin
          total++; bad++;
          $display("FAIL beat32_extra: got %0h expected none",
                   {m32_last, m32_keep, m32_data});
        end else begin
          e = exp32_q.pop_front();
          check("beat32", {m32_last, m32_keep, m32_data}, e);
        end
        if (m32_last && exp_crc32_q.size() != 0)
          check("crc32_out", crc32_out, exp_crc32_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the beat transferred.
  task automatic send8(input logic [7:0] d, input logic k, input logic l);
    int n;
    n = 0;
    s8_valid = 1'b1; s8_data = d; s8_keep = k; s8_last = l;
    @(negedge clk);
    while (!s8_ready && n < 300) begin n++; @(negedge clk); end
    if (!s8_ready) begin
      total++; bad++;
      $display("FAIL send8_timeout: got s_ready=0 expected 1");
    end
    @(posedge clk); #1;
    s8_valid = 1'b0; s8_last = 1'b0;
  endtask

  task automatic send32(input logic [31:0] d, input logic [3:0] k,
                        input logic l);
    int n;
    n = 0;
    s32_valid = 1'b1; s32_data = d; s32_keep = k; s32_last = l;
    @(negedge clk);
    while (!s32_ready && n < 300) begin n++; @(negedge clk); end
    if (!s32_ready) begin
      total++; bad++;
      $display("FAIL send32_timeout: got s_ready=0 expected 1");
    end
    @(posedge clk); #1;
    s32_valid = 1'b0; s32_last = 1'b0;
  endtask

  // Whole 8-bit frame: expected payload + 4 FCS beats queued before sending.
  task automatic frame8(input logic [71:0] data, input int len,
                        input logic [31:0] crc);
    if (len == 0) exp8_q.push_back({1'b0, 1'b0, 8'hAA});
    for (int i = 0; i < len; i++) exp8_q.push_back({1'b0, 1'b1, data[8*i +: 8]});
    for (int k = 0; k < 4; k++) exp8_q.push_back({k == 3, 1'b1, crc[8*k +: 8]});
    exp_crc8_q.push_back(crc);
    if (len == 0) send8(8'hAA, 1'b0, 1'b1);
    for (int i = 0; i < len; i++) send8(data[8*i +: 8], 1'b1, i == len - 1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp8_q.size() != 0 || exp32_q.size() != 0) && n < 500) begin
      @(posedge clk); n++;
    end
    #1;
    check({name, "_drained"}, 64'(exp8_q.size() + exp32_q.size()), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [71:0] data;   // byte i at [8*i +: 8], first on the wire at [7:0]
    int          len;
    logic [31:0] crc;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int d0;
    vecs[0] = '{72'h393837363534333231, 9, 32'hCBF43926};  // "123456789"
    vecs[1] = '{72'h61,                 1, 32'hE8B7BE43};  // "a"
    vecs[2] = '{72'h636261,             3, 32'h352441C2};  // "abc"
    vecs[3] = '{72'h00,                 1, 32'hD202EF8D};  // one zero byte
    vecs[4] = '{72'h00,                 0, 32'h00000000};  // empty, keep=0 last

    // ---- reset values ----
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_m8_valid", m8_valid, 0);
    check("rst_m8_data",  {m8_keep, m8_data, m8_last}, 0);
    check("rst_crc8_out", crc8_out, 0);
    check("rst_crc8_done", crc8_done, 0);
    check("rst_state8", dbg8, 0);
    check("rst_m32", {m32_valid, m32_data, m32_keep, m32_last}, 0);
    check("rst_crc32", {crc32_out, crc32_done}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_s8_ready", s8_ready, 1);
    @(posedge clk); #1;

    // ---- table: back-to-back frames, m_ready=1 ----
    d0 = done8_cnt;
    for (int v = 0; v < 5; v++) frame8(vecs[v].data, vecs[v].len, vecs[v].crc);
    drain("table");
    check("table_done_cnt", 64'(done8_cnt - d0), 5);

    // ---- back-pressure: m_ready toggles every cycle ----
    toggle_rdy = 1'b1;
    d0 = done8_cnt;
    frame8(vecs[0].data, vecs[0].len, vecs[0].crc);
    frame8(vecs[2].data, vecs[2].len, vecs[2].crc);
    drain("bp");
    toggle_rdy = 1'b0;
    @(posedge clk); #1;
    check("bp_done_cnt", 64'(done8_cnt - d0), 2);

    // ---- 32-bit beats ----
    d0 = done32_cnt;
    exp32_q.push_back({1'b0, 4'hF, 32'h34333231});
    exp32_q.push_back({1'b0, 4'hF, 32'h38373635});
    exp32_q.push_back({1'b0, 4'h1, 32'h00000039});
    exp32_q.push_back({1'b1, 4'hF, 32'hCBF43926});
    exp_crc32_q.push_back(32'hCBF43926);
    send32(32'h34333231, 4'hF, 1'b0);
    send32(32'h38373635, 4'hF, 1'b0);
    send32(32'h00000039, 4'h1, 1'b1);
    // "abc" in one beat; the disabled top byte must not be folded
    exp32_q.push_back({1'b0, 4'h7, 32'hFF636261});
    exp32_q.push_back({1'b1, 4'hF, 32'h352441C2});
    exp_crc32_q.push_back(32'h352441C2);
    send32(32'hFF636261, 4'h7, 1'b1);
    // empty frame: keep=0 with last
    exp32_q.push_back({1'b0, 4'h0, 32'h00000000});
    exp32_q.push_back({1'b1, 4'hF, 32'h00000000});
    exp_crc32_q.push_back(32'h00000000);
    send32(32'h00000000, 4'h0, 1'b1);
    drain("w32");
    check("w32_done_cnt", 64'(done32_cnt - d0), 3);

    // ---- flush after 5 bytes, with a competing s_valid ----
    d0 = done8_cnt;
    for (int i = 0; i < 5; i++) begin
      exp8_q.push_back({1'b0, 1'b1, vecs[0].data[8*i +: 8]});
      send8(vecs[0].data[8*i +: 8], 1'b1, 1'b0);
    end
    flush = 1'b1;
    s8_valid = 1'b1; s8_data = 8'h55; s8_keep = 1'b1; s8_last = 1'b1;
    @(negedge clk);
    check("flush_s_ready", s8_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    s8_valid = 1'b0; s8_last = 1'b0;
    @(negedge clk);
    check("flush_m_valid", m8_valid, 0);
    check("flush_crc_keep", crc8_out, 32'h352441C2);
    check("flush_no_done", 64'(done8_cnt - d0), 0);
    @(posedge clk); #1;
    frame8(vecs[0].data, vecs[0].len, vecs[0].crc);
    drain("flush");
    check("flush_crc_out", crc8_out, 32'hCBF43926);
    check("flush_done_cnt", 64'(done8_cnt - d0), 1);

    // ---- reset during the second FCS beat ----
    d0 = done8_cnt;
    for (int i = 0; i < 9; i++) exp8_q.push_back({1'b0, 1'b1, vecs[0].data[8*i +: 8]});
    exp8_q.push_back({1'b0, 1'b1, 8'h26});
    for (int i = 0; i < 9; i++) send8(vecs[0].data[8*i +: 8], 1'b1, i == 8);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!crc8_done && n < 100) begin n++; @(negedge clk); end
      check("rst_mid_done_seen", crc8_done, 1);
    end
    @(posedge clk); #1;
    check("rst_mid_fcs1", {m8_valid, m8_data}, {1'b1, 8'h39});
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_outs", {m8_valid, m8_data, m8_keep, m8_last, crc8_done}, 0);
    check("rst_mid_crc", crc8_out, 0);
    check("rst_mid_q", 64'(exp8_q.size()), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    frame8(vecs[0].data, vecs[0].len, vecs[0].crc);
    drain("rst_mid");
    check("rst_mid_done_cnt", 64'(done8_cnt - d0), 2);

`ifdef CRC32_CHECK_EN
    // ---- check mode: frame carries its own FCS ----
    skip_app_chk = 1'b1;
    d0 = done8_cnt;
    for (int f = 0; f < 2; f++) begin
      logic [7:0] b;
      check_mode8 = 1'b1;
      for (int i = 0; i < 13; i++) begin
        b = (i < 9) ? vecs[0].data[8*i +: 8] : vecs[0].crc[8*(i-9) +: 8];
        if (f == 1 && i == 0) b = b ^ 8'h01;
        exp8_q.push_back({i == 12, 1'b1, b});
        send8(b, 1'b1, i == 12);
        if (i == 0) check_mode8 = 1'b0;
      end
      @(negedge clk);
      check("chk_vld", {crc_ok_vld8, m8_last}, 2'b11);
      check("chk_ok", crc_ok8, (f == 0) ? 1 : 0);
      @(posedge clk); #1;
    end
    drain("chk");
    check("chk_no_done", 64'(done8_cnt - d0), 0);
    skip_app_chk = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before limit");
    $fatal(1, "watchdog");
  end

endmodule
